// File: rtl/store_queue_drain_unit_if.sv
// store_queue_drain_unit_if: commit, SQ read, DCache write and release signals; master = drain unit, slave = its environment
interface store_queue_drain_unit_if #(
  parameter int SQ_ENTRY_NUM     = 16,
  parameter int COMMIT_WIDTH     = 2,
  parameter int BLOCK_ADDR_WIDTH = 30,
  parameter int DATA_WIDTH       = 32
);
  localparam int IW = $clog2(SQ_ENTRY_NUM);
  localparam int CW = $clog2(COMMIT_WIDTH + 1);
  localparam int BW = DATA_WIDTH / 8;
  logic [CW-1:0]               commitStoreNum;
  logic [IW-1:0]               sqReadIndex;
  logic [BLOCK_ADDR_WIDTH-1:0] sqReadBlockAddr;
  logic [BW-1:0]               sqReadByteWE;
  logic [DATA_WIDTH-1:0]       sqReadData;
  logic                        sqReadCondEnabled;
  logic                        dcWrReq;
  logic [BLOCK_ADDR_WIDTH+1:0] dcWrAddr;
  logic [DATA_WIDTH-1:0]       dcWrData;
  logic [BW-1:0]               dcWrByteWE;
  logic                        dcWrAck;
  logic                        dcWrMiss;
  logic                        releaseValid;
  logic [IW-1:0]               releaseIndex;
  logic                        committedStoreEmpty;
  modport master (
    input  commitStoreNum, sqReadBlockAddr, sqReadByteWE, sqReadData, sqReadCondEnabled, dcWrAck, dcWrMiss,
    output sqReadIndex, dcWrReq, dcWrAddr, dcWrData, dcWrByteWE, releaseValid, releaseIndex, committedStoreEmpty
  );
  modport slave (
    output commitStoreNum, sqReadBlockAddr, sqReadByteWE, sqReadData, sqReadCondEnabled, dcWrAck, dcWrMiss,
    input  sqReadIndex, dcWrReq, dcWrAddr, dcWrData, dcWrByteWE, releaseValid, releaseIndex, committedStoreEmpty
  );
endinterface

// File: rtl/store_queue_drain_unit.sv
// store_queue_drain_unit: drains committed stores from the SQ head into the DCache in order; ports clk, rst, sq (master modport)
module store_queue_drain_unit #(
  parameter int SQ_ENTRY_NUM     = 16,
  parameter int COMMIT_WIDTH     = 2,
  parameter int BLOCK_ADDR_WIDTH = 30,
  parameter int DATA_WIDTH       = 32,
  parameter int RETRY_DELAY      = 4
) (
  input logic clk,
  input logic rst,
  store_queue_drain_unit_if.master sq
);
  localparam int IW = $clog2(SQ_ENTRY_NUM);
  localparam int PW = IW + 1;
  localparam int SW = PW + 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam int RW = $clog2(RETRY_DELAY + 1);
  typedef enum logic [1:0] {IDLE, READ, WRITE, WAIT_MISS} state_t;
  state_t                      state_q, state_d;
  logic [IW-1:0]               head_q, head_d, ridx_q, ridx_d;
  logic [PW-1:0]               pending_q, pending_d, avail;
  logic [SW-1:0]               pend_sum;
  logic [RW-1:0]               retry_q, retry_d;
  logic [BLOCK_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic [BW-1:0]               be_q, be_d;
  logic                        rv_q, rv_d;
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    ridx_d = ridx_q;
    retry_d = retry_q;
    addr_d = addr_q;
    data_d = data_q;
    be_d = be_q;
    rv_d = 1'b0;
    pend_sum = {1'b0, pending_q} + SW'(sq.commitStoreNum) - SW'(rv_q);
    pending_d = pend_sum[PW-1:0];
    // entries not yet released: the pending count lags a registered release by one cycle
    avail = pending_q - PW'(rv_q);
    case (state_q)
      IDLE: state_d = avail != '0 ? READ : IDLE;
      READ: begin
        addr_d = sq.sqReadBlockAddr;
        data_d = sq.sqReadData;
        be_d = sq.sqReadByteWE;
        if (!sq.sqReadCondEnabled) begin
          rv_d = 1'b1;
          ridx_d = head_q;
          head_d = head_q + IW'(1);
          state_d = avail > PW'(1) ? READ : IDLE;
        end else state_d = WRITE;
      end
      WRITE: begin
        if (sq.dcWrAck) begin
          rv_d = 1'b1;
          ridx_d = head_q;
          head_d = head_q + IW'(1);
          state_d = avail > PW'(1) ? READ : IDLE;
        end else if (sq.dcWrMiss) begin
          retry_d = RW'(RETRY_DELAY);
          state_d = WAIT_MISS;
        end
      end
      default: begin
        retry_d = retry_q - RW'(1);
        state_d = retry_q <= RW'(1) ? WRITE : WAIT_MISS;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q <= '0;
      ridx_q <= '0;
      pending_q <= '0;
      retry_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      be_q <= '0;
      rv_q <= 1'b0;
    end else begin
      assert (pend_sum <= SW'(SQ_ENTRY_NUM));
      assert (!(state_q == WRITE && sq.dcWrAck && sq.dcWrMiss));
      state_q <= state_d;
      head_q <= head_d;
      ridx_q <= ridx_d;
      pending_q <= pending_d;
      retry_q <= retry_d;
      addr_q <= addr_d;
      data_q <= data_d;
      be_q <= be_d;
      rv_q <= rv_d;
    end
  end
  assign sq.sqReadIndex = head_q;
  assign sq.dcWrReq = state_q == WRITE;
  assign sq.dcWrAddr = {addr_q, 2'b00};
  assign sq.dcWrData = data_q;
  assign sq.dcWrByteWE = be_q;
  assign sq.releaseValid = rv_q;
  assign sq.releaseIndex = ridx_q;
  assign sq.committedStoreEmpty = pending_q == '0 && state_q == IDLE;
endmodule

// File: tb/tb_store_queue_drain_unit.sv
// tb_store_queue_drain_unit: directed table vectors plus wrap and reset sequences for store_queue_drain_unit
module tb_store_queue_drain_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  store_queue_drain_unit_if #(.SQ_ENTRY_NUM(16), .COMMIT_WIDTH(2), .BLOCK_ADDR_WIDTH(30), .DATA_WIDTH(32)) s ();
  store_queue_drain_unit #(.SQ_ENTRY_NUM(16), .COMMIT_WIDTH(2), .BLOCK_ADDR_WIDTH(30), .DATA_WIDTH(32), .RETRY_DELAY(4)) dut (
    .clk(clk),
    .rst(rst),
    .sq(s)
  );
  logic [29:0] addr_m [16];
  logic [31:0] data_m [16];
  logic [3:0]  be_m   [16];
  logic        cond_m [16];
  assign s.sqReadBlockAddr   = addr_m[s.sqReadIndex];
  assign s.sqReadData        = data_m[s.sqReadIndex];
  assign s.sqReadByteWE      = be_m[s.sqReadIndex];
  assign s.sqReadCondEnabled = cond_m[s.sqReadIndex];
  typedef struct {
    logic [1:0]  commit;
    logic        ack, miss, req;
    logic [31:0] addr, data;
    logic [3:0]  be;
    logic        rv;
    logic [3:0]  ridx;
    logic        empty;
  } vec_t;
  vec_t tbl[$];
  int pass = 0;
  int total = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass++;
  endtask
  function automatic vec_t v(input logic [1:0] c, input logic a, input logic m, input logic rq,
                             input logic [31:0] ad, input logic [31:0] dt, input logic [3:0] b,
                             input logic r, input logic [3:0] ri, input logic e);
    vec_t x;
    x.commit = c; x.ack = a; x.miss = m; x.req = rq; x.addr = ad; x.data = dt;
    x.be = b; x.rv = r; x.ridx = ri; x.empty = e;
    return x;
  endfunction
  initial begin
    int committed, rel, cyc, found;
    logic [31:0] held;
    s.commitStoreNum = '0;
    s.dcWrAck = 1'b0;
    s.dcWrMiss = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr_m[i] = 30'h400 + 30'(i);
      data_m[i] = 32'h11111111 * 32'(i);
      be_m[i] = 4'hF;
      cond_m[i] = 1'b1;
    end
    data_m[0] = 32'hDEADBEEF;
    be_m[1] = 4'h3;
    be_m[2] = 4'hC;
    be_m[3] = 4'h1;
    cond_m[4] = 1'b0;
    // single store, two-store burst, miss/retry, failed conditional store
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 32'h1004, 32'h11111111, 4'h3, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 1, 0, 1, 32'h1008, 32'h22222222, 4'hC, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 2, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 32'h100C, 32'h33333333, 4'h1, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 32'h100C, 32'h33333333, 4'h1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 3, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 4, 0));
    tbl.push_back(v(0, 1, 0, 1, 32'h1014, 32'h55555555, 4'hF, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 5, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req", s.dcWrReq, 0);
    chk("rst_rv", s.releaseValid, 0);
    chk("rst_empty", s.committedStoreEmpty, 1);
    chk("rst_idx", s.sqReadIndex, 0);
    chk("rst_addr", s.dcWrAddr, 0);
    chk("rst_data", s.dcWrData, 0);
    chk("rst_be", s.dcWrByteWE, 0);
    foreach (tbl[i]) begin
      chk($sformatf("v%0d_req", i), s.dcWrReq, tbl[i].req);
      chk($sformatf("v%0d_rv", i), s.releaseValid, tbl[i].rv);
      chk($sformatf("v%0d_empty", i), s.committedStoreEmpty, tbl[i].empty);
      if (tbl[i].req) begin
        chk($sformatf("v%0d_addr", i), s.dcWrAddr, tbl[i].addr);
        chk($sformatf("v%0d_data", i), s.dcWrData, tbl[i].data);
        chk($sformatf("v%0d_be", i), s.dcWrByteWE, tbl[i].be);
      end
      if (tbl[i].rv) chk($sformatf("v%0d_ridx", i), s.releaseIndex, tbl[i].ridx);
      s.commitStoreNum = tbl[i].commit;
      s.dcWrAck = tbl[i].ack;
      s.dcWrMiss = tbl[i].miss;
      @(negedge clk);
    end
    s.commitStoreNum = '0;
    s.dcWrAck = 1'b0;
    s.dcWrMiss = 1'b0;
    // 20 stores through a fresh 16-entry queue, always acked at once: release indices wrap 0..15, 0..3
    for (int i = 0; i < 16; i++) begin
      addr_m[i] = 30'h2000 + 30'(i);
      data_m[i] = 32'hA0000000 + 32'(i);
      cond_m[i] = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    committed = 0;
    rel = 0;
    cyc = 0;
    while (rel < 20 && cyc < 300) begin
      if (s.releaseValid) begin
        chk("wrap_ridx", s.releaseIndex, rel % 16);
        rel++;
      end
      if (s.dcWrReq) chk("wrap_addr", s.dcWrAddr, {addr_m[rel % 16], 2'b00});
      s.dcWrAck = s.dcWrReq;
      s.commitStoreNum = (committed < 20 && committed - rel < 16) ? 2'd1 : 2'd0;
      committed += int'(s.commitStoreNum);
      @(negedge clk);
      cyc++;
    end
    s.dcWrAck = 1'b0;
    s.commitStoreNum = '0;
    chk("wrap_done", rel, 20);
    chk("wrap_empty", s.committedStoreEmpty, 1);
    chk("wrap_head", s.sqReadIndex, 4);
    // reset while a write is held without ack
    s.commitStoreNum = 2'd1;
    @(negedge clk);
    s.commitStoreNum = '0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (s.dcWrReq) found = 1;
      else @(negedge clk);
    end
    chk("hold_req_seen", found, 1);
    held = s.dcWrAddr;
    chk("hold_addr", held, {addr_m[4], 2'b00});
    repeat (2) @(negedge clk);
    chk("hold_req_stable", s.dcWrReq, 1);
    chk("hold_addr_stable", s.dcWrAddr, held);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req", s.dcWrReq, 0);
    chk("midrst_rv", s.releaseValid, 0);
    chk("midrst_empty", s.committedStoreEmpty, 1);
    chk("midrst_idx", s.sqReadIndex, 0);
    repeat (3) begin
      @(negedge clk);
      chk("postrst_req", s.dcWrReq, 0);
      chk("postrst_rv", s.releaseValid, 0);
      chk("postrst_empty", s.committedStoreEmpty, 1);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
